// File: rtl/ssc_controller_if.sv
// Control bundle between the selection-sort controller and its datapath.
// Optional feature macro: SSC_CYCLE_CNT_EN adds the cycle_count signal.
interface ssc_controller_if;
  logic       start;
  logic [7:0] cnt1;
  logic [7:0] cnt2;
  logic [1:0] sel_amux;
  logic       sel_dmux;
  logic       sel_mux;
  logic       load_min;
  logic       load_temp;
  logic       mem_write;
  logic       busy;
  logic       done;
`ifdef SSC_CYCLE_CNT_EN
  logic [15:0] cycle_count;
`endif

  // Controller side.
  modport master (
`ifdef SSC_CYCLE_CNT_EN
    output cycle_count,
`endif
    input  start,
    output cnt1, cnt2, sel_amux, sel_dmux, sel_mux,
    output load_min, load_temp, mem_write, busy, done
  );

  // Datapath / requester side.
  modport slave (
`ifdef SSC_CYCLE_CNT_EN
    input  cycle_count,
`endif
    output start,
    input  cnt1, cnt2, sel_amux, sel_dmux, sel_mux,
    input  load_min, load_temp, mem_write, busy, done
  );
endinterface

// File: rtl/ssc_controller.sv
// Selection-sort controller: sequences an external datapath (min/temp registers,
// comparator, combinational-read memory) to sort N_WORDS entries in ascending order.
// Optional feature macro: SSC_CYCLE_CNT_EN adds a 16-bit busy-cycle counter.
module ssc_controller #(
  parameter int unsigned N_WORDS = 16
) (
  input logic            clk,
  input logic            rst_n,
  ssc_controller_if.master bus
);

  localparam logic [7:0] LastJ = 8'(N_WORDS - 1);
  localparam logic [7:0] LastI = 8'(N_WORDS - 2);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StScan,
    StSwapRd,
    StSwapW1,
    StSwapW2,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt1_q, cnt1_d;
  logic [7:0] cnt2_q, cnt2_d;

  logic [1:0] sel_amux;
  logic       sel_dmux;
  logic       sel_mux;
  logic       load_min;
  logic       load_temp;
  logic       mem_write;
  logic       busy;
  logic       done;

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  // Next-state, index updates and per-state datapath controls.
  always_comb begin
    state_d   = state_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    sel_amux  = 2'b00;
    sel_dmux  = 1'b0;
    sel_mux   = 1'b0;
    load_min  = 1'b0;
    load_temp = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt1_d  = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        busy     = 1'b1;
        load_min = 1'b1;
        cnt2_d   = cnt1_q + 8'd1;
        state_d  = StScan;
      end
      StScan: begin
        // Comparator in the datapath updates min on less-than while sel_mux picks cnt2.
        busy     = 1'b1;
        sel_amux = 2'b01;
        sel_mux  = 1'b1;
        if (cnt2_q == LastJ) begin
          state_d = StSwapRd;
        end else begin
          cnt2_d = cnt2_q + 8'd1;
        end
      end
      StSwapRd: begin
        busy      = 1'b1;
        load_temp = 1'b1;
        state_d   = StSwapW1;
      end
      StSwapW1: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        state_d   = StSwapW2;
      end
      StSwapW2: begin
        // Swap is unconditional; when min address equals i it rewrites the same value.
        busy      = 1'b1;
        sel_amux  = 2'b10;
        sel_dmux  = 1'b1;
        mem_write = 1'b1;
        if (cnt1_q == LastI) begin
          state_d = StDone;
        end else begin
          cnt1_d  = cnt1_q + 8'd1;
          state_d = StInit;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cnt1      = cnt1_q;
  assign bus.cnt2      = cnt2_q;
  assign bus.sel_amux  = sel_amux;
  assign bus.sel_dmux  = sel_dmux;
  assign bus.sel_mux   = sel_mux;
  assign bus.load_min  = load_min;
  assign bus.load_temp = load_temp;
  assign bus.mem_write = mem_write;
  assign bus.busy      = busy;
  assign bus.done      = done;

`ifdef SSC_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Busy-cycle counter: cleared when a sort is accepted, held through DONE and IDLE.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == StIdle && bus.start) begin
      cyc_d = '0;
    end else if (busy) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign bus.cycle_count = cyc_q;
`endif

endmodule

// File: doc/ssc_controller.md
SSC_CONTROLLER -- requirements
Module: ssc_controller

Interface
REQ-001 Parameter N_WORDS, default 16, array length sorted; legal range 2..256.
REQ-002 Clk  input  1  single clock; all state on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  sort request; sampled in IDLE only.
REQ-005 Cnt1_Out  output  8  outer index i (current destination slot).
REQ-006 Cnt2_Out  output  8  inner scan index j.
REQ-007 Sel_AMux  output  2  address select to datapath: 00=Cnt1, 01=Cnt2, 10=min address register.
REQ-008 Sel_DMux  output  1  write-data select: 0=min value register, 1=temp register.
REQ-009 Sel_Mux  output  1  min-address source: 0=Cnt1, 1=Cnt2.
REQ-010 Load_Min  output  1  force-load min value/address registers.
REQ-011 Load_Temp  output  1  load temp register from read data.
REQ-012 Mem_Write  output  1  data memory write strobe; memory reads combinationally, writes on Clk edge.
REQ-013 Busy  output  1  high in every non-IDLE, non-DONE state.
REQ-014 Done  output  1  one-cycle completion pulse.

Function
REQ-015 States: IDLE, INIT, SCAN, SWAP_RD, SWAP_W1, SWAP_W2, DONE; encoding is implementer's choice.
REQ-016 IDLE: all strobes 0, Sel_* 0; Start=1 -> Cnt1<=0, go INIT; Start=0 -> stay.
REQ-017 INIT: Sel_AMux=00, Sel_Mux=0, Load_Min=1; Cnt2<=Cnt1+1; go SCAN.
REQ-018 SCAN: Sel_AMux=01, Sel_Mux=1, Load_Min=0 (datapath comparator updates min on less-than); Cnt2 increments each cycle; when Cnt2==N_WORDS-1 go SWAP_RD without incrementing.
REQ-019 SWAP_RD: Sel_AMux=00, Load_Temp=1; go SWAP_W1.
REQ-020 SWAP_W1: Sel_AMux=00, Sel_DMux=0, Mem_Write=1 (min value to slot i); go SWAP_W2.
REQ-021 SWAP_W2: Sel_AMux=10, Sel_DMux=1, Mem_Write=1 (old slot-i value to min address); if Cnt1==N_WORDS-2 go DONE, else Cnt1<=Cnt1+1, go INIT.
REQ-022 DONE: Done=1, Busy=0, strobes 0; unconditionally go IDLE next cycle.
REQ-023 Start while Busy or in DONE is ignored; no queuing.
REQ-024 Swap is always performed, including when min address equals i; the result is then unchanged data.
REQ-025 Busy cycles per sort = 4*(N_WORDS-1) + N_WORDS*(N_WORDS-1)/2; Done asserts the cycle after the last SWAP_W2.
REQ-026 Counters are 8-bit unsigned and never wrap within a legal N_WORDS; Cnt1/Cnt2 hold their values in IDLE and DONE.
REQ-027 Mem_Write is asserted only in SWAP_W1 and SWAP_W2: exactly 2*(N_WORDS-1) writes per sort.

Reset
REQ-028 Rst_n low asynchronously forces IDLE, Cnt1=Cnt2=0, all outputs 0, regardless of current state.
REQ-029 Reset mid-sort abandons the sort without a Done pulse; memory contents are unspecified; the next Start begins a fresh sort.

Configuration
REQ-030 Macro SSC_CYCLE_CNT_EN defined: adds output Cycle_Count[15:0], cleared on Start acceptance and by reset, incremented each Busy cycle, held through DONE and IDLE.
REQ-031 Macro SSC_CYCLE_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-032 N_WORDS=4, memory {3,1,2,0}, Start pulse -> memory {0,1,2,3}, Busy high 18 cycles, single Done pulse.
REQ-033 N_WORDS=4, memory {1,2,3,4} -> memory unchanged, exactly 6 Mem_Write strobes, 18 busy cycles.
REQ-034 N_WORDS=4, memory {5,5,5,5} -> memory unchanged, min address stays at i each pass (no comparator update).
REQ-035 Start held high for 10 cycles mid-sort -> no restart, single Done, correct sorted output.
REQ-036 Rst_n low during SCAN with i=1 -> outputs 0 immediately, no Done; new Start on {4,3,2,1} -> {1,2,3,4}.
REQ-037 SSC_CYCLE_CNT_EN defined, N_WORDS=4 -> Cycle_Count=18 at Done and held until next Start.
